// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control FSM with memory wait timeout, traps and retired-instruction counter
module riscv_mc_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rfwrite,
  output logic [3:0]       ALUop,
  output logic             Use_Imm,
  output logic [2:0]       Op_Extend,
  output logic [1:0]       wb_sel,
  output logic [1:0]       sel_PC,
  output logic [2:0]       br_type,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_error,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5, HALT = 3'd6
  } state_t;
  localparam int WW = $clog2(WAIT_MAX + 2);
  state_t cur, nxt;
  logic [WW-1:0] wcnt;
  logic [3:0] f3op;
  logic set_ill, set_bus, timeout, legal, r_ok;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_sys;
  assign is_r     = opcode == 7'b0110011;
  assign is_i     = opcode == 7'b0010011;
  assign is_ld    = opcode == 7'b0000011;
  assign is_st    = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_sys   = opcode == 7'b1110011;
  assign r_ok     = func7 == 7'b0000000 || (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101));
  assign legal    = (is_r && r_ok) || is_i || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc;
  assign timeout  = wcnt == WW'(WAIT_MAX);
  assign state    = cur;
  assign halt     = cur == HALT;
  // ALU operation for R/I-ALU from func3; func7[5] selects SUB (R only) and SRA (both)
  always_comb begin
    f3op = 4'd0;
    case (func3)
      3'd0: f3op = (is_r && func7[5]) ? 4'd1 : 4'd0;
      3'd1: f3op = 4'd2;
      3'd2: f3op = 4'd3;
      3'd3: f3op = 4'd4;
      3'd4: f3op = 4'd5;
      3'd5: f3op = func7[5] ? 4'd7 : 4'd6;
      3'd6: f3op = 4'd8;
      default: f3op = 4'd9;
    endcase
  end
  // datapath steering decoded from the registered instruction
  always_comb begin
    ALUop     = (is_r || is_i) ? f3op : is_lui ? 4'd10 : is_br ? 4'd1 : 4'd0;
    Use_Imm   = legal && !is_r && !is_br;
    Op_Extend = is_st ? 3'd1 : is_br ? 3'd2 : (is_lui || is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
    wb_sel    = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
    sel_PC    = is_jal ? 2'd1 : is_jalr ? 2'd2 : (is_br && br_taken) ? 2'd1 : 2'd0;
    br_type   = is_br ? func3 : 3'b011;
  end
  // next state and per-state enables; FETCH enables are masked while reset is held
  always_comb begin
    nxt = cur;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    rfwrite = 1'b0;
    set_ill = 1'b0;
    set_bus = 1'b0;
    case (cur)
      FETCH: begin
        imem_req = !reset;
        ir_we = imem_ready && !reset;
        nxt = imem_ready ? DECODE : timeout ? TRAP : FETCH;
        set_bus = !imem_ready && timeout;
      end
      DECODE: begin
        nxt = legal ? EXECUTE : is_sys ? HALT : TRAP;
        set_ill = !legal && !is_sys;
      end
      EXECUTE: nxt = (is_ld || is_st) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_st;
        pc_we = dmem_ready && is_st;
        nxt = dmem_ready ? (is_ld ? WB : FETCH) : timeout ? TRAP : MEM;
        set_bus = !dmem_ready && timeout;
      end
      WB: begin
        rfwrite = !is_br;
        pc_we = 1'b1;
        nxt = FETCH;
      end
      default: nxt = cur;
    endcase
  end
  // state, wait counter (cleared on every state change), sticky trap flags and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= FETCH;
      wcnt <= '0;
      illegal <= 1'b0;
      bus_error <= 1'b0;
      instret <= '0;
    end else begin
      cur <= nxt;
      wcnt <= (nxt != cur) ? '0 : wcnt + WW'(cur == FETCH || cur == MEM);
      illegal <= illegal | set_ill;
      bus_error <= bus_error | set_bus;
      instret <= instret + CNT_W'(pc_we);
    end
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: scoreboard-driven directed bench for the multi-cycle control FSM
module tb_riscv_mc_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rfwrite, Use_Imm, illegal, bus_error, halt;
  logic [3:0] ALUop;
  logic [2:0] Op_Extend, br_type, state;
  logic [1:0] wb_sel, sel_PC;
  logic [31:0] instret;
  int checks = 0, failures = 0, exp_instret = 0;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic bt;
    logic ir, dr; logic [2:0] st; logic [5:0] en; logic dec;
    logic [3:0] alu; logic ui; logic [2:0] ext; logic [1:0] wb, sp; logic [2:0] brt;
  } cyc_t;
  cyc_t q[$];
  cyc_t cur;

  riscv_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .rfwrite(rfwrite), .ALUop(ALUop),
    .Use_Imm(Use_Imm), .Op_Extend(Op_Extend), .wb_sel(wb_sel), .sel_PC(sel_PC), .br_type(br_type),
    .state(state), .illegal(illegal), .bus_error(bus_error), .halt(halt), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_cyc(input logic ir, input logic dr, input logic [2:0] st, input logic [5:0] en, input logic dec);
    cyc_t c;
    c = cur;
    c.ir = ir; c.dr = dr; c.st = st; c.en = en; c.dec = dec;
    q.push_back(c);
  endfunction

  function automatic void set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic bt);
    cur.op = op; cur.f3 = f3; cur.f7 = f7; cur.bt = bt;
  endfunction

  // enables order: {imem_req, dmem_req, dmem_we, ir_we, pc_we, rfwrite}; mem: 0 none, 1 load, 2 store
  task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic bt,
                            input int iw, input int dw, input int mem, input logic rf, input logic [3:0] alu,
                            input logic ui, input logic [2:0] ext, input logic [1:0] wb, input logic [1:0] sp,
                            input logic [2:0] brt);
    set_instr(op, f3, f7, bt);
    cur.alu = alu; cur.ui = ui; cur.ext = ext; cur.wb = wb; cur.sp = sp; cur.brt = brt;
    for (int i = 0; i < iw; i++) push_cyc(1'b0, 1'b0, 3'd0, 6'b100000, 1'b0);
    push_cyc(1'b1, 1'b0, 3'd0, 6'b100100, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd1, 6'b000000, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd2, 6'b000000, 1'b0);
    if (mem == 2) begin
      for (int i = 0; i < dw; i++) push_cyc(1'b0, 1'b0, 3'd3, 6'b011000, 1'b0);
      push_cyc(1'b0, 1'b1, 3'd3, 6'b011010, 1'b1);
    end else begin
      if (mem == 1) begin
        for (int i = 0; i < dw; i++) push_cyc(1'b0, 1'b0, 3'd3, 6'b010000, 1'b0);
        push_cyc(1'b0, 1'b1, 3'd3, 6'b010000, 1'b0);
      end
      push_cyc(1'b0, 1'b0, 3'd4, {5'b00001, rf}, 1'b1);
    end
    exp_instret++;
  endtask

  task automatic push_trap(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] fin, input int n);
    set_instr(op, f3, f7, 1'b0);
    push_cyc(1'b1, 1'b0, 3'd0, 6'b100100, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd1, 6'b000000, 1'b0);
    for (int i = 0; i < n; i++) push_cyc(1'b0, 1'b0, fin, 6'b000000, 1'b0);
  endtask

  task automatic run;
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode = c.op; func3 = c.f3; func7 = c.f7; br_taken = c.bt;
      imem_ready = c.ir; dmem_ready = c.dr;
      #1;
      chk("state", 32'(state), 32'(c.st));
      chk("enables", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, rfwrite}), 32'(c.en));
      if (c.dec) begin
        chk("ALUop", 32'(ALUop), 32'(c.alu));
        chk("Use_Imm", 32'(Use_Imm), 32'(c.ui));
        chk("Op_Extend", 32'(Op_Extend), 32'(c.ext));
        chk("wb_sel", 32'(wb_sel), 32'(c.wb));
        chk("sel_PC", 32'(sel_PC), 32'(c.sp));
        chk("br_type", 32'(br_type), 32'(c.brt));
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_enables", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, rfwrite}), 32'd0);
    chk("rst_flags", 32'({illegal, bus_error, halt}), 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, 32'({illegal, bus_error, halt}), 32'(exp));
    chk("instret", instret, 32'(exp_instret));
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    push_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    chk_flags("add_flags", 3'b000);
    push_instr(7'b0110011, 3'd0, 7'h20, 1'b0, 0, 0, 0, 1'b1, 4'd1, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0110011, 3'd5, 7'h20, 1'b0, 0, 0, 0, 1'b1, 4'd7, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0110011, 3'd3, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd4, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0110011, 3'd4, 7'h00, 1'b0, 2, 0, 0, 1'b1, 4'd5, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0010011, 3'd5, 7'h20, 1'b0, 0, 0, 0, 1'b1, 4'd7, 1'b1, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0010011, 3'd0, 7'h20, 1'b0, 0, 0, 0, 1'b1, 4'd0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0010011, 3'd7, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd9, 1'b1, 3'd0, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0000011, 3'd2, 7'h00, 1'b0, 0, 3, 1, 1'b1, 4'd0, 1'b1, 3'd0, 2'd1, 2'd0, 3'd3); run();
    push_instr(7'b0100011, 3'd2, 7'h00, 1'b0, 0, 0, 2, 1'b0, 4'd0, 1'b1, 3'd1, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b1100011, 3'd0, 7'h00, 1'b1, 0, 0, 0, 1'b0, 4'd1, 1'b0, 3'd2, 2'd0, 2'd1, 3'd0); run();
    push_instr(7'b1100011, 3'd1, 7'h00, 1'b0, 0, 0, 0, 1'b0, 4'd1, 1'b0, 3'd2, 2'd0, 2'd0, 3'd1); run();
    push_instr(7'b1101111, 3'd0, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd0, 1'b1, 3'd4, 2'd2, 2'd1, 3'd3); run();
    push_instr(7'b1100111, 3'd0, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd0, 1'b1, 3'd0, 2'd2, 2'd2, 3'd3); run();
    push_instr(7'b0110111, 3'd0, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd10, 1'b1, 3'd3, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0010111, 3'd0, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd0, 1'b1, 3'd3, 2'd0, 2'd0, 3'd3); run();
    push_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 15, 0, 0, 1'b1, 4'd0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    chk_flags("ready_at_max_flags", 3'b000);
    push_trap(7'b0000000, 3'd0, 7'h00, 3'd5, 3); run();
    chk_flags("illegal_op_flags", 3'b100);
    do_reset();
    push_trap(7'b0110011, 3'd0, 7'h01, 3'd5, 2); run();
    chk_flags("illegal_f7_flags", 3'b100);
    do_reset();
    push_trap(7'b0110011, 3'd1, 7'h20, 3'd5, 2); run();
    chk_flags("illegal_sll20_flags", 3'b100);
    do_reset();
    set_instr(7'b0110011, 3'd0, 7'h00, 1'b0);
    for (int i = 0; i < 16; i++) push_cyc(1'b0, 1'b0, 3'd0, 6'b100000, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd5, 6'b000000, 1'b0);
    push_cyc(1'b1, 1'b0, 3'd5, 6'b000000, 1'b0);
    run();
    chk_flags("timeout_flags", 3'b010);
    do_reset();
    push_trap(7'b1110011, 3'd0, 7'h00, 3'd6, 3); run();
    chk_flags("ecall_flags", 3'b001);
    do_reset();
    set_instr(7'b0000011, 3'd2, 7'h00, 1'b0);
    push_cyc(1'b1, 1'b0, 3'd0, 6'b100100, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd1, 6'b000000, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd2, 6'b000000, 1'b0);
    push_cyc(1'b0, 1'b0, 3'd3, 6'b010000, 1'b0);
    run();
    dmem_ready = 1'b0;
    #1;
    chk("mem_held_state", 32'(state), 32'd3);
    chk("mem_held_req", 32'(dmem_req), 32'd1);
    chk("mem_instret", instret, 32'(exp_instret));
    do_reset();
    push_instr(7'b0110011, 3'd6, 7'h00, 1'b0, 0, 0, 0, 1'b1, 4'd8, 1'b0, 3'd0, 2'd0, 2'd0, 3'd3); run();
    chk_flags("recover_flags", 3'b000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: max cycles waited on a memory handshake before a bus-error trap.
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 opcode/func3/func7  in  7/3/7  fields of the registered instruction (IR); stable from DECODE until next FETCH.
REQ-006 br_taken  in  1  branch comparator result from datapath.
REQ-007 imem_ready, dmem_ready  in  1 each  memory completion for imem_req / dmem_req.
REQ-008 imem_req, dmem_req, dmem_we, ir_we, pc_we, rfwrite  out  1 each  memory requests and register enables.
REQ-009 ALUop  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
REQ-010 Use_Imm  out  1; Op_Extend  out  3 (I0 S1 B2 U3 J4); wb_sel  out  2 (ALU0 MEM1 PC4 2); sel_PC  out  2 (PC+4 0, branch/JAL target 1, ALU result 2).
REQ-011 br_type  out  3  func3 for BRANCH, 3'b011 otherwise.
REQ-012 state  out  3; illegal, bus_error, halt  out  1 each; instret  out  CNT_W.

Function
REQ-013 FSM states: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5, HALT=6.
REQ-014 FETCH: imem_req=1; on imem_ready, ir_we=1 for that cycle, go DECODE; else stay.
REQ-015 DECODE: one cycle; legal opcode -> EXECUTE; SYSTEM (1110011) -> HALT; any other opcode -> TRAP with illegal=1.
REQ-016 Legal opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-017 R-type with func7 not in {0000000, 0100000}, or 0100000 with func3 not in {000,101}, is illegal.
REQ-018 EXECUTE: LOAD/STORE -> MEM; all others -> WB.
REQ-019 ALUop: R/I-ALU decode from func3 (+func7[5] for SUB R-only, SRA both); LOAD/STORE/AUIPC/JAL/JALR -> ADD; LUI -> PASSB; BRANCH -> SUB.
REQ-020 Use_Imm=1 for all legal opcodes except R and BRANCH; Op_Extend per instruction format.
REQ-021 MEM: dmem_req=1, dmem_we=1 for STORE; on dmem_ready, LOAD -> WB, STORE -> FETCH with pc_we=1.
REQ-022 WB: rfwrite=1 except BRANCH; pc_we=1; go FETCH the next cycle.
REQ-023 sel_PC in WB/MEM-exit: JAL 1, JALR 2, BRANCH 1 if br_taken else 0, others 0.
REQ-024 wb_sel: LOAD 1, JAL/JALR 2, others 0.
REQ-025 All enables (ir_we, pc_we, rfwrite, dmem_we, *_req) are 0 outside their stated state; Moore decode from state plus registered opcode.
REQ-026 Wait counter clears on entry to FETCH/MEM and counts each non-ready cycle; counter reaching WAIT_MAX without ready -> TRAP with bus_error=1.
REQ-027 Ready asserted in the same cycle the count reaches WAIT_MAX: ready wins, no trap.
REQ-028 instret increments by 1 on each pc_we pulse; wraps modulo 2^CNT_W.
REQ-029 TRAP and HALT are absorbing: all enables 0, flags held, until reset; halt=1 only in HALT.
REQ-030 Latency: ALU/branch/jump 4 cycles, STORE 4, LOAD 5, with zero-wait memory.

Reset
REQ-031 Reset asserted asynchronously forces state=FETCH, wait counter=0, instret=0, illegal=bus_error=halt=0, all enables 0 in the same cycle.
REQ-032 Reset mid-MEM aborts the access; dmem_req drops immediately; no pc_we or rfwrite is issued.
REQ-033 After reset release, imem_req=1 from the first clock edge.

Verification
REQ-034 ADD (opcode 0110011, func3 000, func7 0), zero-wait -> states 0,1,2,4,0; ALUop=0, rfwrite=1 in WB only, instret=1.
REQ-035 LOAD, dmem_ready after 3 cycles -> MEM held 4 cycles, wb_sel=1, rfwrite=1 in WB, total 8 cycles.
REQ-036 BEQ with br_taken=1 -> ALUop=1, br_type=000, sel_PC=1, rfwrite=0, pc_we=1 in WB.
REQ-037 opcode 0000000 -> TRAP after DECODE, illegal=1, no pc_we, instret unchanged thereafter.
REQ-038 imem_ready held 0, WAIT_MAX=15 -> TRAP with bus_error=1 after 15 wait cycles; variant with ready at count 15 -> DECODE, no trap.
REQ-039 ECALL -> HALT, halt=1; then reset pulse mid-cycle -> state=0, halt=0 immediately.
